// File: rtl/game_sequencer_pkg.sv
// Shared state encoding, BCD constants and the BCD increment helper for the game sequencer.
package game_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAY      = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam logic [15:0] BCD_MAX  = 16'h9999;
  localparam logic [15:0] BCD_ZERO = 16'h0000;

  // Adds one to a 4-digit BCD value, rippling the carry through digits that wrap 9->0.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/game_sequencer_bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, increment and saturation at 9999.
module bcd_counter4
  import game_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] value
);

  // Clear wins over increment; a saturated count ignores further increments.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= BCD_ZERO;
    end else if (clear) begin
      value <= BCD_ZERO;
    end else if (inc && (value != BCD_MAX)) begin
      value <= bcd_inc(value);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Round sequencer: countdown, timed play phase with BCD hit score, and done hold for the display.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned COUNT_FROM   = 3,
  parameter int unsigned GAME_SECONDS = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  logic        hit,
  output logic        start,
  output logic [15:0] count,
  output logic [15:0] score,
  output logic [7:0]  time_left,
  output logic        game_over
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);

  state_t             state;
  logic [DIV_W-1:0]   div_q;
  logic [3:0]         count_q;
  logic               tick;
  logic               score_clear;
  logic               score_inc;

  assign tick        = (div_q == DIV_W'(TICK_DIV - 1));
  assign count       = {12'h000, count_q};
  assign score_clear = (state == ST_COUNTDOWN) && tick && (count_q == 4'd1);
  assign score_inc   = (state == ST_PLAY) && hit;

  // Divider idles at zero outside COUNTDOWN/PLAY so every phase starts with a full second.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      div_q     <= '0;
      count_q   <= 4'(COUNT_FROM);
      time_left <= 8'(GAME_SECONDS);
      start     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + DIV_W'(1);
      case (state)
        ST_IDLE: begin
          div_q <= '0;
          if (go) begin
            state   <= ST_COUNTDOWN;
            count_q <= 4'(COUNT_FROM);
          end
        end
        ST_COUNTDOWN: begin
          if (tick) begin
            if (count_q == 4'd1) begin
              state     <= ST_PLAY;
              div_q     <= '0;
              count_q   <= 4'd0;
              time_left <= 8'(GAME_SECONDS);
              start     <= 1'b1;
            end else begin
              count_q <= count_q - 4'd1;
            end
          end
        end
        ST_PLAY: begin
          if (tick) begin
            if (time_left == 8'd1) begin
              state     <= ST_DONE;
              time_left <= 8'd0;
              game_over <= 1'b1;
            end else begin
              time_left <= time_left - 8'd1;
            end
          end
        end
        ST_DONE: begin
          div_q <= '0;
          if (go) begin
            state     <= ST_COUNTDOWN;
            count_q   <= 4'(COUNT_FROM);
            start     <= 1'b0;
            game_over <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bcd_counter4 u_score (
    .clock (clock),
    .reset (reset),
    .clear (score_clear),
    .inc   (score_inc),
    .value (score)
  );

endmodule
